// File: rtl/ucomb_pkg.sv
// ---------------------------------------------------------------------------
// ucomb_pkg
// Shared definitions for the ucomb datapath self-test logic.
//
// Contents:
//   state_t      - controller states (idle, settle wait, capture, done)
//   UCOMB_IN_W   - width of the datapath input bus
//   LFSR_FB_MASK - feedback taps of the x^27+x^5+x^2+x+1 vector LFSR
//                  (bits 26, 4, 1 and 0 of the current vector)
//   MISR_POLY    - CRC-16-CCITT polynomial used by the signature register
//   MISR_SEED    - value loaded into the signature register at sweep start
//   lfsrNext     - one shift-left step of the vector LFSR
// ---------------------------------------------------------------------------
package ucomb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int UCOMB_IN_W = 27;

   localparam logic [UCOMB_IN_W-1:0] LFSR_FB_MASK = 27'h4000013;
   localparam logic [15:0]           MISR_POLY    = 16'h1021;
   localparam logic [15:0]           MISR_SEED    = 16'hFFFF;

   // Fibonacci step: the XOR of the tapped bits is shifted in at bit 0
   // while the top bit falls off the end.
   function automatic logic [UCOMB_IN_W-1:0] lfsrNext(input logic [UCOMB_IN_W-1:0] q);
      return {q[UCOMB_IN_W-2:0], ^(q & LFSR_FB_MASK)};
   endfunction

endpackage

// File: rtl/ucomb_misr.sv
// ---------------------------------------------------------------------------
// ucomb_misr
// Multiple-input signature register. It folds one response word into a
// running signature per enabled cycle. Written generically so that other
// gate testers can reuse it.
//
// Ports:
//   clock   in   1       clock
//   reset   in   1       asynchronous reset, active-high (loads SEED)
//   clear   in   1       synchronous reload of SEED (wins over enable)
//   enable  in   1       fold data into the signature this cycle
//   data    in   OUT_W   response word, zero-extended to SIG_W
//   sig     out  SIG_W   current signature
// ---------------------------------------------------------------------------
module ucomb_misr
   import ucomb_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter int               OUT_W = 6,
   parameter logic [SIG_W-1:0] POLY  = MISR_POLY,
   parameter logic [SIG_W-1:0] SEED  = MISR_SEED
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [OUT_W-1:0] data,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] rSig;
   logic [SIG_W-1:0] wFold;

   // One LFSR step of the signature (shift left, XOR the polynomial in
   // when the top bit falls out), then the response word is mixed into
   // the low bits.
   always_comb begin
      wFold = {rSig[SIG_W-2:0], 1'b0}
            ^ (rSig[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-OUT_W){1'b0}}, data};
   end

   // The signature register. Clear has priority so that a new sweep
   // always begins from the seed even if a capture would coincide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rSig <= SEED;
      end else if (clear) begin
         rSig <= SEED;
      end else if (enable) begin
         rSig <= wFold;
      end
   end

   assign sig = rSig;

endmodule

// File: rtl/ucomb_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ucomb_bist_ctrl
// Sequencer and self-test controller for the ucomb_full combinational
// datapath. It drives the datapath input bus from a register and samples
// the datapath output after SETTLE wait cycles. It supports two kinds of
// operation: a single manual vector (valid/ready in, one-cycle response
// pulse out), or an autonomous sweep. A sweep takes its vectors from a
// counter or an LFSR and compresses the responses into a MISR signature.
//
// Ports:
//   wb_clk_i    in   1      clock
//   wb_rst_i    in   1      asynchronous reset, active-high
//   start       in   1      begin a sweep (acted on in IDLE or DONE)
//   abort       in   1      return to IDLE next cycle, beats start
//   mode_lfsr   in   1      sweep source 0=counter 1=LFSR, latched at start
//   seed        in   IN_W   LFSR seed (zero replaced by 1), latched at start
//   num_vec     in   CNT_W  vectors per sweep, latched at start
//   man_valid   in   1      manual vector request
//   man_vec     in   IN_W   manual vector
//   man_ready   out  1      manual request can be taken this cycle
//   resp_valid  out  1      one-cycle pulse, resp_data holds a response
//   resp_data   out  OUT_W  captured datapath output of a manual op
//   dut_in      out  IN_W   registered datapath input drive
//   dut_out     in   OUT_W  datapath output
//   busy        out  1      operation in progress (WAIT or CAPT)
//   done        out  1      sticky sweep-complete flag
//   vec_cnt     out  CNT_W  vectors captured in the current/last sweep
//   signature   out  SIG_W  MISR signature
// ---------------------------------------------------------------------------
module ucomb_bist_ctrl
   import ucomb_pkg::*;
#(
   parameter int IN_W   = UCOMB_IN_W,
   parameter int OUT_W  = 6,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16,
   parameter int SIG_W  = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start,
   input  logic             abort,
   input  logic             mode_lfsr,
   input  logic [IN_W-1:0]  seed,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             man_valid,
   input  logic [IN_W-1:0]  man_vec,
   output logic             man_ready,
   output logic             resp_valid,
   output logic [OUT_W-1:0] resp_data,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [SIG_W-1:0] signature
);

   localparam int                WCNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(SETTLE - 1);

   state_t            rState;
   logic [WCNT_W-1:0] rWaitCnt;
   logic              rManual;
   logic              rModeLfsr;
   logic [CNT_W-1:0]  rNumVec;
   logic [IN_W-1:0]   rDutIn;
   logic [OUT_W-1:0]  rRespData;
   logic              rRespValid;
   logic              rDone;
   logic [CNT_W-1:0]  rVecCnt;

   logic              wStartOk;
   logic [IN_W-1:0]   wSeed;
   logic [IN_W-1:0]   wNextVec;
   logic              wMisrClear;
   logic              wMisrEnable;
   logic [SIG_W-1:0]  wSig;

   // Sweep bookkeeping decoded from the current state. A start is only
   // acted on from IDLE or DONE and never together with abort. The next
   // vector always derives from the vector currently driven, so the
   // latched seed only matters for the first vector.
   always_comb begin
      wStartOk    = start && !abort && (rState == ST_IDLE || rState == ST_DONE);
      wSeed       = (seed == '0) ? IN_W'(1) : seed;
      wNextVec    = rModeLfsr ? lfsrNext(rDutIn) : rDutIn + IN_W'(1);
      wMisrClear  = wStartOk;
      wMisrEnable = !abort && (rState == ST_CAPT) && !rManual;
   end

   // Main controller. Each vector spends SETTLE cycles in WAIT (counter
   // loaded with SETTLE-1 and counted down to zero) and one cycle in
   // CAPT, so a sweep vector costs SETTLE+1 cycles. Abort overrides
   // everything else and leaves done, signature and vec_cnt as they are.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rState     <= ST_IDLE;
         rWaitCnt   <= '0;
         rManual    <= 1'b0;
         rModeLfsr  <= 1'b0;
         rNumVec    <= '0;
         rDutIn     <= '0;
         rRespData  <= '0;
         rRespValid <= 1'b0;
         rDone      <= 1'b0;
         rVecCnt    <= '0;
      end else begin
         rRespValid <= 1'b0;
         if (abort) begin
            rState  <= ST_IDLE;
            rManual <= 1'b0;
         end else begin
            case (rState)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     rModeLfsr <= mode_lfsr;
                     rNumVec   <= num_vec;
                     rVecCnt   <= '0;
                     rManual   <= 1'b0;
                     if (num_vec == '0) begin
                        rDone  <= 1'b1;
                        rState <= ST_DONE;
                     end else begin
                        rDone    <= 1'b0;
                        rDutIn   <= mode_lfsr ? wSeed : '0;
                        rWaitCnt <= WAIT_LOAD;
                        rState   <= ST_WAIT;
                     end
                  end else if (rState == ST_IDLE && man_valid) begin
                     rDutIn   <= man_vec;
                     rManual  <= 1'b1;
                     rWaitCnt <= WAIT_LOAD;
                     rState   <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (rWaitCnt == '0) begin
                     rState <= ST_CAPT;
                  end else begin
                     rWaitCnt <= rWaitCnt - WCNT_W'(1);
                  end
               end
               ST_CAPT: begin
                  if (rManual) begin
                     rRespData  <= dut_out;
                     rRespValid <= 1'b1;
                     rManual    <= 1'b0;
                     rState     <= ST_IDLE;
                  end else begin
                     rVecCnt <= rVecCnt + CNT_W'(1);
                     if (rVecCnt + CNT_W'(1) == rNumVec) begin
                        rDone  <= 1'b1;
                        rState <= ST_DONE;
                     end else begin
                        rDutIn   <= wNextVec;
                        rWaitCnt <= WAIT_LOAD;
                        rState   <= ST_WAIT;
                     end
                  end
               end
               default: rState <= ST_IDLE;
            endcase
         end
      end
   end

   ucomb_misr #(
      .SIG_W (SIG_W),
      .OUT_W (OUT_W),
      .POLY  (SIG_W'(MISR_POLY)),
      .SEED  (SIG_W'(MISR_SEED))
   ) misrInst (
      .clock  (wb_clk_i),
      .reset  (wb_rst_i),
      .clear  (wMisrClear),
      .enable (wMisrEnable),
      .data   (dut_out),
      .sig    (wSig)
   );

   assign man_ready  = (rState == ST_IDLE) && !start;
   assign busy       = (rState == ST_WAIT) || (rState == ST_CAPT);
   assign resp_valid = rRespValid;
   assign resp_data  = rRespData;
   assign dut_in     = rDutIn;
   assign done       = rDone;
   assign vec_cnt    = rVecCnt;
   assign signature  = wSig;

endmodule
